// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: drains a FIFO read port in bursts of up to BURST_LEN words.
// A 2-entry skid buffer absorbs the FIFO's 1-cycle read latency and feeds a
// valid/ready stream; out_last tags the final word of each burst. A FIFO holding
// fewer than BURST_LEN words is flushed as a short burst after TIMEOUT idle cycles.
module fifo_burst_reader #(
  parameter int WIDTH     = 8,
  parameter int PTR       = 4,
  parameter int BURST_LEN = 8,
  parameter int TIMEOUT   = 16
) (
  input  logic             rdclk,
  input  logic             reset,
  output logic             fifo_rden,
  input  logic [WIDTH-1:0] fifo_dataout,
  input  logic             fifo_rdempty,
  input  logic [PTR:0]     fifo_rdusedw,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic [15:0]      burst_cnt
);

  localparam int          TW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [PTR:0] BLEN   = (PTR+1)'(BURST_LEN);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BURST, FLUSH} state_t;

  state_t         state;
  logic [PTR:0]   remaining;
  logic [TW-1:0]  timer;
  logic           inflight;
  logic           inflight_last;

  // skid entries: e0 is the head and drives the stream directly
  logic             v0, v1;
  logic [WIDTH-1:0] d0, d1;
  logic             l0, l1;

  logic       pop;
  logic       push;
  logic [1:0] level;

  assign out_valid = v0;
  assign out_data  = d0;
  assign out_last  = l0;

  assign pop  = v0 & out_ready;
  assign push = inflight;

  // Occupancy counts the word leaving this cycle as already gone, so a full
  // pipeline (one buffered, one in flight) keeps reading while the sink drains
  // it; this is what sustains one word per cycle. Worst case stays at 2 entries.
  assign level = {1'b0, v0} + {1'b0, v1} + {1'b0, inflight} - {1'b0, pop};

  // Reset gates the request so no word is popped from the FIFO only to be discarded.
  assign fifo_rden = !reset && (state == BURST) && !fifo_rdempty &&
                     (remaining != '0) && (level < 2'd2);

  // Burst control FSM plus the read-latency tracker
  always_ff @(posedge rdclk) begin
    if (reset) begin
      state         <= IDLE;
      remaining     <= '0;
      timer         <= '0;
      burst_cnt     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      inflight      <= fifo_rden;
      inflight_last <= fifo_rden && (remaining == (PTR+1)'(1));
      case (state)
        IDLE: begin
          if (fifo_rdusedw >= BLEN) begin
            state     <= BURST;
            remaining <= BLEN;
            timer     <= '0;
          end else if (fifo_rdusedw != '0) begin
            if (timer == TLAST) begin
              state     <= BURST;
              remaining <= fifo_rdusedw;
              timer     <= '0;
            end else begin
              timer <= timer + 1'b1;
            end
          end else begin
            timer <= '0;
          end
        end
        BURST: begin
          if (remaining == '0)
            state <= FLUSH;
          else if (fifo_rden)
            remaining <= remaining - 1'b1;
        end
        FLUSH: begin
          if (!inflight && !v0 && !v1) begin
            state     <= IDLE;
            burst_cnt <= burst_cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Two-entry skid: captured words enter behind the head, pops shift forward
  always_ff @(posedge rdclk) begin
    if (reset) begin
      v0 <= 1'b0;
      v1 <= 1'b0;
      d0 <= '0;
      d1 <= '0;
      l0 <= 1'b0;
      l1 <= 1'b0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (!v0) begin
            v0 <= 1'b1;
            d0 <= fifo_dataout;
            l0 <= inflight_last;
          end else begin
            v1 <= 1'b1;
            d1 <= fifo_dataout;
            l1 <= inflight_last;
          end
        end
        2'b01: begin
          v0 <= v1;
          d0 <= d1;
          l0 <= l1 & v1;
          v1 <= 1'b0;
          l1 <= 1'b0;
        end
        2'b11: begin
          if (v1) begin
            d0 <= d1;
            l0 <= l1;
            d1 <= fifo_dataout;
            l1 <= inflight_last;
          end else begin
            d0 <= fifo_dataout;
            l0 <= inflight_last;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
